// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
//   sm9_t        : 9-bit sign-magnitude value, bit 8 = sign, bits 7:0 = magnitude
//   pool_state_t : max-pool reducer state encoding
package tpu_pkg;

   typedef logic [8:0] sm9_t;

   localparam int   SM9_SIGN_BIT = 8;
   localparam sm9_t SM9_POS_ZERO = 9'h000;
   localparam sm9_t SM9_NEG_ZERO = 9'h100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } pool_state_t;

endpackage

// File: rtl/max_9bit.sv
// Combinational sign-magnitude maximum of two 9-bit values.
// Ports:
//   inputA  : first operand; also the tie winner
//   inputB  : second operand
//   max_out : larger of the two in sign-magnitude order
// Ordering: any positive beats any negative (so +0 beats -0); among
// positives the larger magnitude wins, among negatives the smaller one.
module max_9bit
   import tpu_pkg::*;
(
   input  logic [8:0] inputA,
   input  logic [8:0] inputB,
   output logic [8:0] max_out
);

   logic b_wins;

   always_comb begin
      b_wins = 1'b0;
      case ({inputA[SM9_SIGN_BIT], inputB[SM9_SIGN_BIT]})
         2'b00:   b_wins = (inputB[7:0] > inputA[7:0]);
         2'b01:   b_wins = 1'b0;
         2'b10:   b_wins = 1'b1;
         default: b_wins = (inputB[7:0] < inputA[7:0]);
      endcase
      max_out = b_wins ? inputB : inputA;
   end

endmodule

// File: rtl/maxpool_9bit.sv
// Streaming max-pool reducer: folds each group of WINDOW sign-magnitude
// beats into one running maximum and emits it through a single-entry
// output register.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake
//   in_data               : 9-bit sign-magnitude input
//   flush                 : close the current window early
//   out_valid/out_ready   : pooled result handshake
//   out_data              : pooled maximum
// Build option: define MAXPOOL_RELU_EN for fused ReLU (accumulator seeded
// with +0 so results are never negative).
//
// state | meaning
// IDLE  | no beats held, output register empty
// ACCUM | window partly collected in acc, count = beats so far
// EMIT  | result held in out_data until downstream takes it
module maxpool_9bit
   import tpu_pkg::*;
#(
   parameter int WINDOW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] in_data,
   input  logic       flush,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_data
);

   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

   pool_state_t      state;
   logic [CNT_W-1:0] count;
   sm9_t             acc;
   sm9_t             fresh;
   sm9_t             cmp_a;
   sm9_t             max_res;
   logic             accept;
   logic             xfer;
   logic             close;

   // Seed for a new window: the beat itself, or +0 when ReLU is fused.
`ifdef MAXPOOL_RELU_EN
   assign fresh = SM9_POS_ZERO;
`else
   assign fresh = in_data;
`endif

   assign cmp_a    = (state == ACCUM) ? acc : fresh;
   assign in_ready = (state != EMIT) || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   // count is 0 outside ACCUM, so this also covers WINDOW==1 from IDLE/EMIT.
   assign close    = flush || (count == LAST);

   max_9bit u_max (
      .inputA  (cmp_a),
      .inputB  (in_data),
      .max_out (max_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         acc       <= SM9_POS_ZERO;
         out_valid <= 1'b0;
         out_data  <= SM9_POS_ZERO;
      end else begin
         case (state)
            IDLE, EMIT: begin
               if (state == EMIT && xfer) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               // In EMIT a beat can only be accepted alongside a transfer.
               if (accept) begin
                  acc <= max_res;
                  if (close) begin
                     out_data  <= max_res;
                     out_valid <= 1'b1;
                     count     <= '0;
                     state     <= EMIT;
                  end else begin
                     count <= CNT_W'(1);
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= max_res;
                  if (close) begin
                     out_data  <= max_res;
                     out_valid <= 1'b1;
                     count     <= '0;
                     state     <= EMIT;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end else if (flush) begin
                  out_data  <= acc;
                  out_valid <= 1'b1;
                  count     <= '0;
                  state     <= EMIT;
               end
            end
            default: begin
               state     <= IDLE;
               count     <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_9bit.sv
module tb_maxpool_9bit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_data;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;

   int errors;
   int checks;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   maxpool_9bit #(.WINDOW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every result transfer; inputs are stable between #1 after posedge
   // and the next posedge, so the negedge view matches the transferring edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back(out_data);
   end

   task automatic beat(input logic [8:0] d, input logic f);
      in_valid = 1'b1;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic window4(input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] c, input logic [8:0] d);
      beat(a, 1'b0);
      beat(b, 1'b0);
      beat(c, 1'b0);
      beat(d, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_basic;
      beat(9'h005, 1'b0);
      beat(9'h10A, 1'b0);
      beat(9'h003, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", out_valid); end
      beat(9'h07F, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      checks++;
      if (out_data !== 9'h07F) begin errors++; $display("FAIL basic_data got=%h exp=07f", out_data); end
      exp_q.push_back(9'h07F);
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
      idle(1);
   endtask

   task automatic test_negative;
      logic [8:0] e;
`ifdef MAXPOOL_RELU_EN
      e = 9'h000;
`else
      e = 9'h102;
`endif
      window4(9'h105, 9'h102, 9'h1FF, 9'h110);
      checks++;
      if (out_data !== e || out_valid !== 1'b1) begin
         errors++; $display("FAIL negative_data got=%h/%b exp=%h/1", out_data, out_valid, e);
      end
      exp_q.push_back(e);
      idle(2);
   endtask

   task automatic test_zero_and_tie;
      window4(9'h100, 9'h000, 9'h100, 9'h100);
      checks++;
      if (out_data !== 9'h000 || out_valid !== 1'b1) begin
         errors++; $display("FAIL zero_sign got=%h/%b exp=000/1", out_data, out_valid);
      end
      exp_q.push_back(9'h000);
      idle(2);
      window4(9'h042, 9'h042, 9'h042, 9'h042);
      checks++;
      if (out_data !== 9'h042 || out_valid !== 1'b1) begin
         errors++; $display("FAIL tie got=%h/%b exp=042/1", out_data, out_valid);
      end
      exp_q.push_back(9'h042);
      idle(2);
   endtask

   task automatic test_back_to_back;
      window4(9'h001, 9'h002, 9'h003, 9'h004);
      checks++;
      if (out_data !== 9'h004 || out_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_first got=%h/%b exp=004/1", out_data, out_valid);
      end
      exp_q.push_back(9'h004);
      beat(9'h081, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", out_valid); end
      beat(9'h082, 1'b0);
      beat(9'h080, 1'b0);
      beat(9'h100, 1'b0);
      checks++;
      if (out_data !== 9'h082 || out_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_second got=%h/%b exp=082/1", out_data, out_valid);
      end
      exp_q.push_back(9'h082);
      idle(2);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      window4(9'h010, 9'h020, 9'h030, 9'h040);
      exp_q.push_back(9'h040);
      in_valid = 1'b1;
      in_data  = 9'h011;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 9'h040) begin
            errors++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=040/1", i, out_data, out_valid);
         end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", out_valid); end
      beat(9'h001, 1'b0);
      beat(9'h002, 1'b0);
      beat(9'h003, 1'b0);
      checks++;
      if (out_data !== 9'h011 || out_valid !== 1'b1) begin
         errors++; $display("FAIL release_window got=%h/%b exp=011/1", out_data, out_valid);
      end
      exp_q.push_back(9'h011);
      idle(2);
   endtask

   task automatic test_flush;
      beat(9'h020, 1'b0);
      beat(9'h030, 1'b1);
      checks++;
      if (out_data !== 9'h030 || out_valid !== 1'b1) begin
         errors++; $display("FAIL flush_partial got=%h/%b exp=030/1", out_data, out_valid);
      end
      exp_q.push_back(9'h030);
      beat(9'h001, 1'b0);
      beat(9'h007, 1'b0);
      beat(9'h002, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_fresh_count got=%b exp=0", out_valid); end
      beat(9'h003, 1'b0);
      checks++;
      if (out_data !== 9'h007 || out_valid !== 1'b1) begin
         errors++; $display("FAIL flush_next_window got=%h/%b exp=007/1", out_data, out_valid);
      end
      exp_q.push_back(9'h007);
      idle(2);
   endtask

   task automatic test_flush_corners;
      in_valid = 1'b0;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_ignored got=%b exp=0", out_valid); end
      beat(9'h055, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (out_data !== 9'h055 || out_valid !== 1'b1) begin
         errors++; $display("FAIL flush_no_beat got=%h/%b exp=055/1", out_data, out_valid);
      end
      exp_q.push_back(9'h055);
      beat(9'h066, 1'b1);
      checks++;
      if (out_data !== 9'h066 || out_valid !== 1'b1) begin
         errors++; $display("FAIL flush_in_emit got=%h/%b exp=066/1", out_data, out_valid);
      end
      exp_q.push_back(9'h066);
      idle(2);
   endtask

   task automatic test_reset_mid;
      int n_before;
      beat(9'h070, 1'b0);
      beat(9'h071, 1'b0);
      beat(9'h072, 1'b0);
      n_before = got_q.size();
      rst = 1'b1;
      idle(1);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_outputs got=%b/%h/%b exp=0/000/1", out_valid, out_data, in_ready);
      end
      rst = 1'b0;
      beat(9'h001, 1'b0);
      beat(9'h002, 1'b0);
      beat(9'h003, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_count got=%b exp=0", out_valid); end
      beat(9'h004, 1'b0);
      checks++;
      if (out_data !== 9'h004 || out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_reset_window got=%h/%b exp=004/1", out_data, out_valid);
      end
      exp_q.push_back(9'h004);
      idle(2);
      checks++;
      if (got_q.size() !== n_before + 1) begin
         errors++; $display("FAIL mid_reset_beats got=%0d exp=%0d", got_q.size(), n_before + 1);
      end
   endtask

   task automatic test_stream_log;
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL log_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL log_entry idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 9'h000;
      flush     = 1'b0;
      out_ready = 1'b1;
      test_reset;
      test_basic;
      test_negative;
      test_zero_and_tie;
      test_back_to_back;
      test_backpressure;
      test_flush;
      test_flush_corners;
      test_reset_mid;
      test_stream_log;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
